// File: rtl/lz77_stream_ctrl.sv
// ---------------------------------------------------------------------------
// lz77_stream_ctrl
//
// Sequences one LZ77 compression block at a time. It sits between an
// upstream byte stream, the LZ77 encoder core and a downstream token consumer.
//   1. Holds the core in reset while idle.
//   2. Streams exactly BLOCK_LEN characters into the core, one per cycle, with
//      no gaps. If upstream is not valid on a beat, PAD_CHAR is sent instead.
//   3. Captures the core's one-cycle token pulses into a small first-word
//      fall-through FIFO. The FIFO offers valid/ready backpressure downstream.
//   4. Waits for the core to finish and the FIFO to drain, then pulses done.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start                 begin a block (honoured only when idle)
//   in_valid/in_data      upstream byte stream
//   in_ready              high for exactly BLOCK_LEN consecutive cycles per block
//   enc_reset             registered reset to the encoder core
//   enc_chardata          character presented to the core during LOAD
//   enc_valid/enc_finish  core token pulse / core finished level
//   enc_offset/enc_match_len/enc_char_nxt   core token fields
//   out_valid/out_ready   downstream handshake for the FIFO head
//   out_offset/out_len/out_char             FIFO head token fields
//   busy, done            block in progress / one-cycle completion pulse
//   token_count           tokens captured in the current block (saturating)
//   err_underrun          sticky: upstream not valid on a load beat
//   err_overflow          sticky: token arrived while the FIFO was full
// ---------------------------------------------------------------------------
module lz77_stream_ctrl #(
    parameter int         BLOCK_LEN  = 8192,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] PAD_CHAR   = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        enc_reset,
    output logic [7:0]  enc_chardata,
    input  logic        enc_valid,
    input  logic        enc_finish,
    input  logic [4:0]  enc_offset,
    input  logic [4:0]  enc_match_len,
    input  logic [7:0]  enc_char_nxt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_offset,
    output logic [4:0]  out_len,
    output logic [7:0]  out_char,
    output logic        busy,
    output logic        done,
    output logic [13:0] token_count,
    output logic        err_underrun,
    output logic        err_overflow
);

    localparam int CNT_W  = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam int TOK_W  = 18;

    localparam logic [CNT_W-1:0]  LOAD_LAST  = CNT_W'(BLOCK_LEN - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(FIFO_DEPTH);
    localparam logic [13:0]       TOKEN_SAT  = 14'h3FFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ENCODE = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]  load_cnt_reg;
    logic              enc_reset_reg;
    logic [13:0]       token_count_reg;
    logic              err_underrun_reg;
    logic              err_overflow_reg;

    logic [TOK_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [FCNT_W-1:0] fifo_count_reg;

    // Handshake / event decodes shared by the FSM and the datapath.
    logic accept_start;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic push_ok;
    logic overflow;

    assign accept_start = (state_reg == S_IDLE) && start;
    assign fifo_full    = (fifo_count_reg == FIFO_FULL);
    assign fifo_empty   = (fifo_count_reg == '0);
    assign pop          = !fifo_empty && out_ready;
    assign push         = enc_valid && (state_reg != S_IDLE);
    // A pop in the same cycle frees the slot the push needs, so a full FIFO
    // only overflows when nothing is leaving.
    assign push_ok      = push && (!fifo_full || pop);
    assign overflow     = push && fifo_full && !pop;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_cnt_reg == LOAD_LAST) begin
                    state_next = S_ENCODE;
                end
            end
            S_ENCODE: begin
                if (enc_finish) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave only when the FIFO is empty and no late token is
                // arriving in this cycle.
                if (fifo_empty && !push) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready     = 1'b0;
        enc_chardata = 8'h00;
        busy         = (state_reg != S_IDLE);
        done         = 1'b0;
        case (state_reg)
            S_LOAD: begin
                in_ready     = 1'b1;
                enc_chardata = in_valid ? in_data : PAD_CHAR;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Load counter and encoder reset
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt_reg  <= '0;
            enc_reset_reg <= 1'b1;
        end else begin
            if (accept_start) begin
                load_cnt_reg  <= '0;
                enc_reset_reg <= 1'b0;
            end else if (state_reg == S_LOAD) begin
                load_cnt_reg <= load_cnt_reg + CNT_W'(1);
            end
            // The core goes back into reset on the edge that leaves DONE.
            if (state_reg == S_DONE) begin
                enc_reset_reg <= 1'b1;
            end
        end
    end

    assign enc_reset = enc_reset_reg;

    // -----------------------------------------------------------------------
    // Token counter and sticky error flags. They are cleared only by an
    // accepted start, so they stay stable after DONE.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            token_count_reg  <= '0;
            err_underrun_reg <= 1'b0;
            err_overflow_reg <= 1'b0;
        end else if (accept_start) begin
            token_count_reg  <= '0;
            err_underrun_reg <= 1'b0;
            err_overflow_reg <= 1'b0;
        end else begin
            // Dropped tokens are still counted: the count reflects the
            // tokens the core produced.
            if (push && (token_count_reg != TOKEN_SAT)) begin
                token_count_reg <= token_count_reg + 14'd1;
            end
            if ((state_reg == S_LOAD) && !in_valid) begin
                err_underrun_reg <= 1'b1;
            end
            if (overflow) begin
                err_overflow_reg <= 1'b1;
            end
        end
    end

    assign token_count  = token_count_reg;
    assign err_underrun = err_underrun_reg;
    assign err_overflow = err_overflow_reg;

    // -----------------------------------------------------------------------
    // Token FIFO (first-word fall-through). A reset discards the contents by
    // clearing the pointers, so the storage itself needs no reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= {enc_offset, enc_match_len, enc_char_nxt};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            // Pointer width equals log2(FIFO_DEPTH), so wrap is implicit.
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + FCNT_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - FCNT_W'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    logic [TOK_W-1:0] head_tok;
    assign head_tok   = fifo_mem[rd_ptr_reg];
    assign out_valid  = !fifo_empty;
    assign out_offset = head_tok[17:13];
    assign out_len    = head_tok[12:8];
    assign out_char   = head_tok[7:0];

endmodule

// File: tb/tb_lz77_stream_ctrl.sv
module tb_lz77_stream_ctrl;

    localparam int         BLOCK_LEN  = 8192;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [7:0] PAD        = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        enc_reset;
    logic [7:0]  enc_chardata;
    logic        enc_valid = 1'b0;
    logic        enc_finish = 1'b0;
    logic [4:0]  enc_offset = 5'd0;
    logic [4:0]  enc_match_len = 5'd0;
    logic [7:0]  enc_char_nxt = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_offset;
    logic [4:0]  out_len;
    logic [7:0]  out_char;
    logic        busy;
    logic        done;
    logic [13:0] token_count;
    logic        err_underrun;
    logic        err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] rx_q[$];
    logic [17:0] exp_q[$];

    lz77_stream_ctrl #(
        .BLOCK_LEN (BLOCK_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PAD_CHAR  (PAD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .enc_reset    (enc_reset),
        .enc_chardata (enc_chardata),
        .enc_valid    (enc_valid),
        .enc_finish   (enc_finish),
        .enc_offset   (enc_offset),
        .enc_match_len(enc_match_len),
        .enc_char_nxt (enc_char_nxt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_offset   (out_offset),
        .out_len      (out_len),
        .out_char     (out_char),
        .busy         (busy),
        .done         (done),
        .token_count  (token_count),
        .err_underrun (err_underrun),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    // Downstream consumer: record every accepted token. Sampled on the
    // falling edge; inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            rx_q.push_back({out_offset, out_len, out_char});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] tok(input logic [4:0] o, input logic [4:0] l, input logic [7:0] c);
        return {o, l, c};
    endfunction

    task automatic send_token(input logic [17:0] t);
        enc_valid     = 1'b1;
        enc_offset    = t[17:13];
        enc_match_len = t[12:8];
        enc_char_nxt  = t[7:0];
        tick();
        enc_valid = 1'b0;
    endtask

    task automatic pulse_finish();
        enc_finish = 1'b1;
        tick();
        enc_finish = 1'b0;
    endtask

    // Pulse start, then feed beats while in_ready is high. ub = beat with
    // in_valid low (-1: none); abort_at = beat at which reset is asserted.
    task automatic do_load(input int ub, input int abort_at, input bit uniform, output int beats);
        logic [7:0] d;
        beats = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < BLOCK_LEN + 100; c++) begin
            if (!in_ready) break;
            d = uniform ? 8'h41 : 8'(beats * 3 + 1);
            if (beats == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_enc_reset", 32'(enc_reset), 32'd1);
                check("abort_in_ready", 32'(in_ready), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                return;
            end
            in_valid = (beats != ub);
            in_data  = d;
            #1;
            if (beats == 0) begin
                check("beat0_char", 32'(enc_chardata), 32'(d));
                check("load_enc_reset", 32'(enc_reset), 32'd0);
                check("start_clr_udr", 32'(err_underrun), 32'd0);
                check("start_clr_ovf", 32'(err_overflow), 32'd0);
                check("start_clr_cnt", 32'(token_count), 32'd0);
            end
            if (beats == ub) begin
                check("underrun_pad", 32'(enc_chardata), 32'(PAD));
            end
            beats++;
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_done(input int limit, output bit found);
        found = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", 32'(found), 32'd1);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            $display("%s token %0d: off=%0d len=%0d char=%02h", tag, i,
                     rx_q[i][17:13], rx_q[i][12:8], rx_q[i][7:0]);
            check({tag, "_tok"}, 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int  beats;
        bit  found;

        // ---------------- reset state ----------------
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        tick();
        check("rst_enc_reset", 32'(enc_reset), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(token_count), 32'd0);
        check("rst_errs", 32'({err_underrun, err_overflow}), 32'd0);
        check("idle_chardata", 32'(enc_chardata), 32'd0);
        reset = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;

        // ---------------- uniform input ----------------
        out_ready = 1'b1;
        do_load(-1, -1, 1'b1, beats);
        check("uni_beats", 32'(beats), 32'(BLOCK_LEN));
        check("uni_in_ready_off", 32'(in_ready), 32'd0);
        exp_q.delete();
        rx_q.delete();
        exp_q.push_back(tok(5'd0, 5'd0, 8'h41));
        exp_q.push_back(tok(5'd0, 5'd24, 8'h41));
        exp_q.push_back(tok(5'd0, 5'd24, 8'h41));
        exp_q.push_back(tok(5'd0, 5'd24, 8'h41));
        exp_q.push_back(tok(5'd0, 5'd24, 8'h24));
        foreach (exp_q[i]) send_token(exp_q[i]);
        check("uni_count", 32'(token_count), 32'd5);
        pulse_finish();
        wait_done(40, found);
        // start during DONE must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("uni_busy_fall", 32'(busy), 32'd0);
        check("uni_done_once", 32'(done), 32'd0);
        check("uni_enc_reset", 32'(enc_reset), 32'd1);
        tick();
        tick();
        check("done_start_ign", 32'(busy), 32'd0);
        check("uni_count_hold", 32'(token_count), 32'd5);
        check("uni_errs", 32'({err_underrun, err_overflow}), 32'd0);
        compare_rx("uni");

        // ---------------- underrun + full-FIFO collision ----------------
        out_ready = 1'b0;
        do_load(100, -1, 1'b0, beats);
        check("udr_beats", 32'(beats), 32'(BLOCK_LEN));
        check("udr_flag", 32'(err_underrun), 32'd1);
        exp_q.delete();
        rx_q.delete();
        exp_q.push_back(tok(5'd1, 5'd3, 8'h10));
        exp_q.push_back(tok(5'd2, 5'd4, 8'h11));
        exp_q.push_back(tok(5'd3, 5'd5, 8'h12));
        exp_q.push_back(tok(5'd4, 5'd6, 8'h13));
        exp_q.push_back(tok(5'd5, 5'd7, 8'h14));
        for (int i = 0; i < 4; i++) send_token(exp_q[i]);
        // 5th token meets a pop on a full FIFO; start here is also ignored
        out_ready = 1'b1;
        start     = 1'b1;
        send_token(exp_q[4]);
        out_ready = 1'b0;
        start     = 1'b0;
        check("coll_ovf", 32'(err_overflow), 32'd0);
        check("coll_count", 32'(token_count), 32'd5);
        check("enc_start_ign", 32'({busy, in_ready}), 32'b10);
        check("coll_head", 32'({out_offset, out_len, out_char}), 32'(exp_q[1]));
        out_ready = 1'b1;
        pulse_finish();
        wait_done(40, found);
        check("udr_sticky", 32'(err_underrun), 32'd1);
        check("coll_ovf_done", 32'(err_overflow), 32'd0);
        tick();
        compare_rx("coll");

        // ---------------- backpressure overflow ----------------
        out_ready = 1'b0;
        do_load(-1, -1, 1'b0, beats);
        check("bp_beats", 32'(beats), 32'(BLOCK_LEN));
        exp_q.delete();
        rx_q.delete();
        exp_q.push_back(tok(5'd0, 5'd0, 8'h61));
        exp_q.push_back(tok(5'd1, 5'd2, 8'h62));
        exp_q.push_back(tok(5'd7, 5'd9, 8'h63));
        exp_q.push_back(tok(5'd31, 5'd31, 8'hFF));
        send_token(exp_q[0]);
        send_token(exp_q[1]);
        send_token(exp_q[2]);
        send_token(exp_q[3]);
        check("bp_no_ovf4", 32'(err_overflow), 32'd0);
        send_token(tok(5'd9, 5'd9, 8'h99));
        check("bp_ovf", 32'(err_overflow), 32'd1);
        check("bp_count", 32'(token_count), 32'd5);
        check("bp_head", 32'({out_valid, out_offset, out_len, out_char}), 32'({1'b1, exp_q[0]}));
        pulse_finish();
        tick();
        tick();
        check("bp_drain_hold", 32'({busy, done}), 32'b10);
        out_ready = 1'b1;
        wait_done(40, found);
        check("bp_ovf_done", 32'(err_overflow), 32'd1);
        tick();
        check("bp_ovf_idle", 32'(err_overflow), 32'd1);
        compare_rx("bp");

        // ---------------- reset mid-LOAD ----------------
        do_load(-1, 3000, 1'b0, beats);
        check("abort_beats", 32'(beats), 32'd3000);
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        rx_q.delete();
        tick();
        check("abort_idle", 32'({busy, out_valid, enc_reset}), 32'b001);
        do_load(-1, -1, 1'b1, beats);
        check("reload_beats", 32'(beats), 32'(BLOCK_LEN));
        pulse_finish();
        wait_done(40, found);
        check("reload_count", 32'(token_count), 32'd0);
        check("reload_rx", 32'(rx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
